// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the channel readout arbiter.
//   - control-word (CW) field positions
//   - filler word written when a block is aborted on timeout
//   - arbiter FSM state encoding
package arb_pkg;

  // CW layout: [15] flag, [14:9] channel, [8:0] body length L
  localparam int CW_FLAG = 15;
  localparam int CH_HI   = 14;
  localparam int CH_LO   = 9;
  localparam int LEN_HI  = 8;
  localparam int LEN_LO  = 0;

  localparam logic [15:0] FILLER = 16'h7FFF;

  // The header check is combinational inside SCAN, so it needs no state.
  typedef enum logic [1:0] {
    SCAN = 2'd0,
    BODY = 2'd1,
    NEXT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_ofifo.sv
// arb_ofifo: synchronous first-word-fall-through FIFO for the framed stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write side; a write while full is ignored
//   rd_en             pop the head word (ignored while empty)
//   rd_data, rd_valid head word (zero while empty) and non-empty flag
//   free              registered free-entry count (DEPTH after reset)
module arb_ofifo #(
  parameter int W     = 18,
  parameter int ABITS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_data,
  input  logic           rd_en,
  output logic [W-1:0]   rd_data,
  output logic           rd_valid,
  output logic [ABITS:0] free
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] FULL_CNT = (ABITS+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [ABITS-1:0] wptr_q, rptr_q;
  logic [ABITS:0]   count_q, count_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && (count_q != FULL_CNT);
  assign do_rd = rd_en && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)
      count_d = count_q + (ABITS+1)'(1);
    else if (!do_wr && do_rd)
      count_d = count_q - (ABITS+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      free    <= FULL_CNT;
    end else begin
      if (do_wr) wptr_q <= wptr_q + ABITS'(1);
      if (do_rd) rptr_q <= rptr_q + ABITS'(1);
      count_q <= count_d;
      // free follows the post-edge occupancy so the arbiter sees it one
      // cycle later as a plain register
      free    <= FULL_CNT - count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wr_data;
  end

  assign rd_valid = (count_q != '0);
  // gate the head word so the outputs read zero while empty
  assign rd_data  = rd_valid ? mem[rptr_q] : '0;

endmodule

// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin collector of trigger blocks from the channel
// readout bus, merged into one framed 16-bit stream.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   give          one-hot registered read request to channel cur
//   have          per-channel acknowledge (combinational from give)
//   din           shared data bus, valid when give[i] & have[i]
//   chmask        1 = channel skipped by the scan
//   odata/osof/oeof/ovalid, oready  framed output stream
//   blk_done      1-clk pulse per block completely written to the FIFO
//   err           1-clk pulse on a protocol error (bad CW, flagged body
//                 word, timeout)
//   busy          FSM is not in SCAN
//   dbg_state     current FSM state
//
// Handshakes: on the bus, a word moves on every rising edge where
// give[cur] & have[cur]; on the output, a word moves on every rising edge
// where ovalid & oready, and odata/osof/oeof hold steady while ovalid is
// high and oready is low.
module chan_arbiter
  import arb_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int OBITS = 4,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [NCH-1:0]   give,
  input  logic [NCH-1:0]   have,
  input  logic [15:0]      din,
  input  logic [NCH-1:0]   chmask,
  output logic [15:0]      odata,
  output logic             osof,
  output logic             oeof,
  output logic             ovalid,
  input  logic             oready,
  output logic             blk_done,
  output logic             err,
  output logic             busy,
  output arb_state_e       dbg_state
);

  localparam int CURW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW   = $clog2(TMO + 1);

  arb_state_e      state_q, state_d;
  logic [CURW-1:0] cur_q, cur_d, cur_inc;
  logic [NCH-1:0]  give_d;
  logic [8:0]      rem_q, rem_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_d, err_d;
  logic            consumed, space, hdr_ok, give_en;
  logic            wr_en;
  logic [17:0]     wr_data, rd_data;
  logic [OBITS:0]  free;

  assign consumed = give[cur_q] & have[cur_q];
  // Two free entries cover the word that may land on the edge that
  // samples free plus the word requested by the give issued on that edge.
  assign space    = free >= (OBITS+1)'(2);
  assign cur_inc  = (cur_q == CURW'(NCH - 1)) ? '0 : cur_q + CURW'(1);
  assign hdr_ok   = din[CW_FLAG] && (din[CH_HI:CH_LO] == 6'(cur_q));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    wr_en   = 1'b0;
    wr_data = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (give[cur_q]) begin
          if (have[cur_q]) begin
            if (hdr_ok) begin
              wr_en   = 1'b1;
              wr_data = {1'b1, din[LEN_HI:LEN_LO] == 9'd0, din};
              rem_d   = din[LEN_HI:LEN_LO];
              tmo_d   = '0;
              if (din[LEN_HI:LEN_LO] == 9'd0) begin
                state_d = NEXT;
                done_d  = 1'b1;
              end else begin
                state_d = BODY;
              end
            end else begin
              err_d   = 1'b1;
              state_d = NEXT;
            end
          end else begin
            cur_d = cur_inc;
          end
        end else if (chmask[cur_q]) begin
          cur_d = cur_inc;
        end
        // unmasked with give low: waiting for FIFO space, stay on cur
      end
      BODY: begin
        if (consumed) begin
          wr_en   = 1'b1;
          wr_data = {1'b0, rem_q == 9'd1, din};
          rem_d   = rem_q - 9'd1;
          tmo_d   = '0;
          if (din[CW_FLAG]) err_d = 1'b1;
          if (rem_q == 9'd1) begin
            state_d = NEXT;
            done_d  = 1'b1;
          end
        end else if (give[cur_q]) begin
          // stalled with give high; frozen while give is low for space
          if (tmo_q == TW'(TMO - 1)) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, 1'b1, FILLER};
            err_d   = 1'b1;
            state_d = NEXT;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      NEXT: begin
        cur_d   = cur_inc;
        state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase

    // give is registered: decide it from the state and index of next cycle
    give_en = space && (((state_d == SCAN) && !chmask[cur_d]) || (state_d == BODY));
    give_d  = give_en ? (NCH'(1) << cur_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      cur_q    <= '0;
      give     <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      blk_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      give     <= give_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      blk_done <= done_d;
      err      <= err_d;
    end
  end

  arb_ofifo #(
    .W     (18),
    .ABITS (OBITS)
  ) u_ofifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (oready),
    .rd_data  (rd_data),
    .rd_valid (ovalid),
    .free     (free)
  );

  assign {osof, oeof, odata} = rd_data;
  assign busy      = (state_q != SCAN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chan_arbiter.sv
module tb_chan_arbiter;
  import arb_pkg::*;

  localparam int NCH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic [NCH-1:0] give, have, chmask;
  logic [15:0]    din, odata;
  logic           osof, oeof, ovalid, oready, blk_done, err, busy;
  arb_state_e     dbg_state;

  chan_arbiter #(.NCH(NCH), .OBITS(4), .TMO(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .give      (give),
    .have      (have),
    .din       (din),
    .chmask    (chmask),
    .odata     (odata),
    .osof      (osof),
    .oeof      (oeof),
    .ovalid    (ovalid),
    .oready    (oready),
    .blk_done  (blk_done),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- channel models ----------------
  // Each channel is a word list; it acknowledges whenever it is asked and
  // still has words, and presents its next word on the bus.
  logic [15:0] ch_mem [NCH][1024];
  int          ch_wr [NCH];
  int          ch_rd [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ch_rd[i] <= 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (give[i] && have[i]) ch_rd[i] <= ch_rd[i] + 1;
    end
  end

  always_comb begin
    have = '0;
    din  = 16'h0000;
    for (int i = 0; i < NCH; i++) begin
      if (give[i] && (ch_rd[i] < ch_wr[i])) begin
        have[i] = 1'b1;
        din     = ch_mem[i][ch_rd[i]];
      end
    end
  end

  task automatic push_word(input int c, input logic [15:0] w);
    ch_mem[c][ch_wr[c]] = w;
    ch_wr[c]++;
  endtask

  function automatic logic [15:0] mk_cw(input int c, input int len);
    return {1'b1, 6'(c), 9'(len)};
  endfunction

  task automatic push_block(input int c, input int len);
    push_word(c, mk_cw(c, len));
    for (int k = 0; k < len; k++) push_word(c, 16'($urandom_range(0, 16'h7FFF)));
  endtask

  // ---------------- scoreboard ----------------
  logic [17:0]    exp_q [$];
  logic [17:0]    sb_exp;
  int             exp_blk, exp_err;
  int             blk_seen, err_seen, extra_cnt, hot_bad;
  logic [NCH-1:0] mask_hit;

  always @(negedge clk) begin
    if (!rst_n) begin
      blk_seen  = 0;
      err_seen  = 0;
      extra_cnt = 0;
      hot_bad   = 0;
      mask_hit  = '0;
    end else begin
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          extra_cnt++;
        end else begin
          sb_exp = exp_q.pop_front();
          chk("out_word", {14'd0, osof, oeof, odata}, {14'd0, sb_exp});
        end
      end
      blk_seen += int'(blk_done);
      err_seen += int'(err);
      if ($countones(give) > 1) hot_bad++;
      mask_hit |= give & chmask;
    end
  end

  // Reference: block-level round-robin over the preloaded channel lists.
  // From pointer p, the first unmasked channel with words left is served,
  // then p moves past it. A served word that is not a CW for that channel
  // is dropped with an error; a CW brings L body words, or the filler with
  // eof and an error when the channel runs dry before L.
  task automatic build_model(input logic [NCH-1:0] mask);
    int pos [NCH];
    int p, c, len;
    bit found, aborted;
    logic [15:0] w;
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    p = 0;
    do begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && !mask[(p + k) % NCH] && pos[(p + k) % NCH] < ch_wr[(p + k) % NCH]) begin
          found = 1'b1;
          c = (p + k) % NCH;
        end
      end
      if (found) begin
        w = ch_mem[c][pos[c]];
        pos[c]++;
        if (w[15] && (w[14:9] == 6'(c))) begin
          len = int'(w[8:0]);
          exp_q.push_back({1'b1, len == 0, w});
          aborted = 1'b0;
          for (int k = 1; k <= len; k++) begin
            if (!aborted) begin
              if (pos[c] < ch_wr[c]) begin
                w = ch_mem[c][pos[c]];
                pos[c]++;
                exp_q.push_back({1'b0, k == len, w});
                if (w[15]) exp_err++;
              end else begin
                exp_q.push_back({1'b0, 1'b1, 16'h7FFF});
                exp_err++;
                aborted = 1'b1;
              end
            end
          end
          if (!aborted) exp_blk++;
        end else begin
          exp_err++;
        end
        p = (c + 1) % NCH;
      end
    end while (found);
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_phase(input logic [NCH-1:0] mask);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) ch_wr[i] = 0;
    chmask  = mask;
    oready  = 1'b1;
    exp_blk = 0;
    exp_err = 0;
  endtask

  task automatic release_reset();
    build_model(chmask);
    @(negedge clk);
    chk("rst_give", give, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_osof", osof, 0);
    chk("rst_oeof", oeof, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, SCAN);
    rst_n = 1'b1;
  endtask

  task automatic run_phase(input string name, input int min_cyc, input int stall, input bit rnd_rdy);
    int cyc;
    release_reset();
    cyc = 0;
    while ((exp_q.size() != 0 || cyc < min_cyc) && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == stall) begin
        chk({name, ".stall_give"}, give, 0);
        chk({name, ".stall_ovalid"}, ovalid, 1);
      end
      if (cyc < stall)  oready = 1'b0;
      else if (rnd_rdy) oready = ($urandom_range(0, 3) != 0);
      else              oready = 1'b1;
    end
    chk({name, ".drain_left"}, exp_q.size(), 0);
    oready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({name, ".blk_done"}, blk_seen, exp_blk);
    chk({name, ".err"}, err_seen, exp_err);
    chk({name, ".extra"}, extra_cnt, 0);
    chk({name, ".onehot"}, hot_bad, 0);
    chk({name, ".masked_give"}, mask_hit, 0);
    chk({name, ".busy_idle"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NCH-1:0] m;
    logic [15:0]    w;
    int             len, nb;

    chmask = '0;
    oready = 1'b1;
    for (int i = 0; i < NCH; i++) ch_wr[i] = 0;

    // single block on ch3, CW 0x8605
    begin_phase('0);
    push_word(3, 16'h8605);
    for (int k = 0; k < 5; k++) push_word(3, 16'(16'h1100 + k));
    run_phase("ch3", 0, 0, 0);

    // two blocks each on ch0..2: served 0,1,2,0,1,2
    begin_phase('0);
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 3; c++) push_block(c, 2 + b + c);
    run_phase("rr3", 0, 0, 0);

    // masked channel with data waiting
    begin_phase(16'h0002);
    push_block(1, 4);
    run_phase("mask1", 200, 0, 0);

    // 509-word block with the output stalled
    begin_phase('0);
    push_block(7, 509);
    run_phase("stall", 0, 300, 0);

    // bad CW on ch2, good block on ch3
    begin_phase('0);
    push_word(2, 16'h8A03);
    push_block(3, 3);
    run_phase("badcw", 0, 0, 0);

    // flagged body word is forwarded with an error
    begin_phase('0);
    push_word(9, mk_cw(9, 3));
    push_word(9, 16'h0123);
    push_word(9, 16'h8123);
    push_word(9, 16'h0456);
    run_phase("flag", 0, 0, 0);

    // channel goes silent after 2 of 5 body words
    begin_phase('0);
    push_word(5, mk_cw(5, 5));
    push_word(5, 16'h0AAA);
    push_word(5, 16'h0BBB);
    run_phase("tmo", 400, 0, 0);

    // reset in the middle of a long block, then normal traffic
    begin_phase('0);
    push_block(4, 100);
    release_reset();
    repeat (40) @(posedge clk);
    begin_phase('0);
    push_block(4, 3);
    push_block(6, 2);
    run_phase("after_rst", 0, 0, 0);

    // randomized traffic
    for (int ph = 0; ph < 8; ph++) begin
      m = '0;
      for (int i = 0; i < NCH; i++) m[i] = ($urandom_range(0, 3) == 0);
      begin_phase(m);
      for (int c = 0; c < NCH; c++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 9) == 0) begin
            w = {1'b1, 6'((c + 1 + $urandom_range(0, 5)) % 64), 9'($urandom_range(0, 511))};
            if ($urandom_range(0, 1) == 0) w[15] = 1'b0;
            push_word(c, w);
          end else begin
            len = $urandom_range(0, 12);
            push_word(c, mk_cw(c, len));
            for (int k = 0; k < len; k++) begin
              w = 16'($urandom_range(0, 16'h7FFF));
              if ($urandom_range(0, 19) == 0) w[15] = 1'b1;
              push_word(c, w);
            end
          end
        end
      end
      run_phase($sformatf("rand%0d", ph), 0, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
